// File: rtl/xpb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | xpb_pkg                                                               |
// | Shared widths and state encoding for the XPB reduction datapath.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package xpb_pkg;

  localparam int WORD_BITS  = 1024;
  localparam int DIGIT_BITS = 5;
  localparam int NUM_DIGITS = 8;
  localparam int SEL_BITS   = $clog2(NUM_DIGITS);
  localparam int ACC_BITS   = WORD_BITS + $clog2(NUM_DIGITS);
  localparam int HI_BITS    = NUM_DIGITS * DIGIT_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } xpb_state_e;

endpackage
`default_nettype wire

// File: rtl/xpb_wide_add.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | xpb_wide_add                                                          |
// | Combinational wide unsigned adder for the XPB accumulator.            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module xpb_wide_add #(
  parameter int WIDTH = xpb_pkg::ACC_BITS
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule
`default_nettype wire

// File: rtl/xpb_digit_accum.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | xpb_digit_accum                                                       |
// | Walks the high-part word digit by digit through the XPB ROMs and      |
// | accumulates the looked-up values into a wide sum.                     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module xpb_digit_accum
  import xpb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [HI_BITS-1:0]    in_hi,
  output logic [SEL_BITS-1:0]   lut_sel,
  output logic [DIGIT_BITS-1:0] lut_digit,
  input  logic [WORD_BITS-1:0]  lut_xpb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_BITS-1:0]   out_sum,
  output logic                  busy
);

  xpb_state_e            state_q, state_d;
  logic [SEL_BITS-1:0]   idx_q, idx_d;
  logic [HI_BITS-1:0]    hi_q, hi_d;
  logic [WORD_BITS-1:0]  xpb_q, xpb_d;
  logic                  xpb_v_q, xpb_v_d;
  logic [ACC_BITS-1:0]   acc_q, acc_d;
  logic [ACC_BITS-1:0]   add_sum;

  xpb_wide_add #(
    .WIDTH (ACC_BITS)
  ) u_add (
    .a_i   (acc_q),
    .b_i   ({{(ACC_BITS-WORD_BITS){1'b0}}, xpb_q}),
    .sum_o (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hi_q    <= '0;
      xpb_q   <= '0;
      xpb_v_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      xpb_q   <= xpb_d;
      xpb_v_q <= xpb_v_d;
      acc_q   <= acc_d;
    end
  end

  // Lookup results are registered one cycle before they are added, so the
  // last digit's value is still in flight during DRAIN.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hi_d      = hi_q;
    xpb_d     = xpb_q;
    xpb_v_d   = 1'b0;
    acc_d     = xpb_v_q ? add_sum : acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sum   = '0;
    lut_sel   = '0;
    lut_digit = '0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          hi_d    = in_hi;
          idx_d   = '0;
          acc_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lut_sel   = idx_q;
        lut_digit = hi_q[idx_q*DIGIT_BITS +: DIGIT_BITS];
        xpb_d     = lut_xpb;
        xpb_v_d   = 1'b1;
        idx_d     = idx_q + 1'b1;
        if (idx_q == SEL_BITS'(NUM_DIGITS-1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        out_sum   = acc_q;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_xpb_digit_accum.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_xpb_digit_accum                                                    |
// | Scoreboard bench: random words vs. an arithmetic ROM/sum model.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_xpb_digit_accum;
  import xpb_pkg::*;

  typedef struct {
    logic [ACC_BITS-1:0] sum;
    longint              acc_cyc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [HI_BITS-1:0]    in_hi = '0;
  logic [SEL_BITS-1:0]   lut_sel;
  logic [DIGIT_BITS-1:0] lut_digit;
  logic [WORD_BITS-1:0]  lut_xpb;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [ACC_BITS-1:0]   out_sum;
  logic                  busy;

  bit     rom_mode = 1'b0;
  bit     check_gap = 1'b0;
  longint cyc = 0;
  longint last_acc = 0;
  int     n_total = 0;
  int     n_pass = 0;
  bit     prev_valid = 1'b0;
  exp_t   sbq[$];

  xpb_digit_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_hi     (in_hi),
    .lut_sel   (lut_sel),
    .lut_digit (lut_digit),
    .lut_xpb   (lut_xpb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WORD_BITS-1:0] rom_val(input int sel, input int dig, input bit mode);
    if (mode) return {WORD_BITS{1'b1}};
    return WORD_BITS'((sel + 1) * dig);
  endfunction

  function automatic logic [ACC_BITS-1:0] model_sum(input logic [HI_BITS-1:0] w, input bit mode);
    logic [ACC_BITS-1:0] s = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      s = s + ACC_BITS'(rom_val(k, int'(w[k*DIGIT_BITS +: DIGIT_BITS]), mode));
    return s;
  endfunction

  assign lut_xpb = rom_val(int'(lut_sel), int'(lut_digit), rom_mode);

  task automatic chk(input string nm, input logic [ACC_BITS-1:0] act, input logic [ACC_BITS-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act_hi=%h act_lo=%h exp_hi=%h exp_lo=%h",
                  nm, act[ACC_BITS-1:960], act[63:0], exp[ACC_BITS-1:960], exp[63:0]);
  endtask

  // Monitor: compares every presented sum against the head of the scoreboard.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        chk("out_expected", ACC_BITS'(sbq.size() != 0), 1);
        if (sbq.size() != 0) chk("latency", ACC_BITS'(cyc - sbq[0].acc_cyc), 9);
      end
      if (out_valid && sbq.size() != 0) begin
        chk("out_sum", out_sum, sbq[0].sum);
        if (out_ready) void'(sbq.pop_front());
      end
    end
    prev_valid = out_valid;
  end

  task automatic send(input logic [HI_BITS-1:0] w, input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", ACC_BITS'(in_ready), 1);
      return;
    end
    in_valid = 1'b1;
    in_hi    = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (check_gap) chk("issue_gap", ACC_BITS'(cyc - last_acc), 11);
    last_acc = cyc;
    e.sum     = model_sum(w, rom_mode);
    e.acc_cyc = cyc;
    if (push) sbq.push_back(e);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      @(negedge clk);
      chk("lut_sel", ACC_BITS'(lut_sel), ACC_BITS'(k));
      chk("lut_digit", ACC_BITS'(lut_digit), ACC_BITS'(w[k*DIGIT_BITS +: DIGIT_BITS]));
      chk("busy", ACC_BITS'(busy), 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", ACC_BITS'(sbq.size()), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, ACC_BITS'(in_ready), 1);
    chk({tag, "_out_valid"}, ACC_BITS'(out_valid), 0);
    chk({tag, "_out_sum"}, out_sum, '0);
    chk({tag, "_busy"}, ACC_BITS'(busy), 0);
    chk({tag, "_lut_sel"}, ACC_BITS'(lut_sel), 0);
    chk({tag, "_lut_digit"}, ACC_BITS'(lut_digit), 0);
  endtask

  initial begin
    logic [HI_BITS-1:0] w;
    logic [ACC_BITS-1:0] big;
    int n;

    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero word.
    send('0, 1'b1);
    drain();

    // Single nonzero digit at position 3: (3+1)*5.
    w = HI_BITS'(5) << (3*DIGIT_BITS);
    chk("model_d3", model_sum(w, 1'b0), 20);
    send(w, 1'b1);
    drain();

    // Saturated ROM values exercise the top accumulator bits.
    rom_mode = 1'b1;
    big = ACC_BITS'({WORD_BITS{1'b1}}) * 8;
    chk("model_max", model_sum({HI_BITS{1'b1}}, 1'b1), big);
    send({HI_BITS{1'b1}}, 1'b1);
    drain();
    rom_mode = 1'b0;

    // Backpressure in DONE with in_valid pulses that must be ignored.
    out_ready = 1'b0;
    send({$urandom, $urandom}, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", ACC_BITS'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_hi    = {$urandom, $urandom};
      chk("bp_in_ready", ACC_BITS'(in_ready), 0);
      chk("bp_valid_hold", ACC_BITS'(out_valid), 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_back_idle", ACC_BITS'(in_ready), 1);
    chk("bp_popped", ACC_BITS'(sbq.size()), 0);
    send({$urandom, $urandom}, 1'b1);
    drain();

    // Asynchronous reset during the digit-4 lookup.
    @(negedge clk);
    in_valid = 1'b1;
    in_hi    = {$urandom, $urandom};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_sel", ACC_BITS'(lut_sel), 4);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(negedge clk);
    chk_reset_outputs("arst_next");
    rst_n = 1'b1;
    send({$urandom, $urandom}, 1'b1);
    drain();

    // Back-to-back random words with out_ready held high.
    send({$urandom, $urandom}, 1'b1);
    check_gap = 1'b1;
    for (int i = 0; i < 5; i++) send({$urandom, $urandom}, 1'b1);
    check_gap = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/xpb_digit_accum.md
# xpb_digit_accum

Sequential reduction accumulator for the modular-square datapath. It takes the high-part word above the modulus boundary and walks it one 5-bit digit per cycle. Each digit goes out to the bank of precomputed XPB lookup ROMs, and the returned 1024-bit value is added into a wide accumulator. The finished sum goes downstream to the final modular-fold stage over a valid/ready handshake.

## Interface
- WORD_BITS, 1024, width of each XPB lookup value.
- DIGIT_BITS, 5, digit width; a ROM has 2^DIGIT_BITS entries.
- NUM_DIGITS, 8, digits per high-part word; also the number of ROM positions.
- SEL_BITS, $clog2(NUM_DIGITS), ROM-position select width.
- ACC_BITS, WORD_BITS+$clog2(NUM_DIGITS), accumulator width (1027 at defaults).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  high-part word offered.
- in_ready  out  1  block can accept a word.
- in_hi  in  NUM_DIGITS*DIGIT_BITS  high-part word; digit k is in_hi[k*DIGIT_BITS +: DIGIT_BITS].
- lut_sel  out  SEL_BITS  ROM position being looked up.
- lut_digit  out  DIGIT_BITS  digit presented to that ROM.
- lut_xpb  in  WORD_BITS  combinational ROM result for (lut_sel, lut_digit), valid in the same cycle.
- out_valid  out  1  accumulated sum available.
- out_ready  in  1  downstream accepts the sum.
- out_sum  out  ACC_BITS  sum of the NUM_DIGITS looked-up values.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: latch in_hi into hi_q, set idx=0, clear acc, go to ISSUE.
- **ISSUE**
  - Drive lut_sel=idx and lut_digit=hi_q digit idx.
  - Register lut_xpb into xpb_q and set xpb_v=1.
  - Increment idx. When idx==NUM_DIGITS-1, go to DRAIN.
- **DRAIN**
  - xpb_v=0 after the edge; no new lookup.
  - Go to DONE.
- **Accumulate, every edge:** if xpb_v, acc <= acc + zero-extend(xpb_q).
  - Unsigned, no modular wrap. Each ROM value is < 2^WORD_BITS, so NUM_DIGITS of them fit in ACC_BITS and overflow is impossible.
- **DONE**
  - out_valid=1 and out_sum=acc, both held stable.
  - On out_ready, go to IDLE.
- in_ready is 0 in every non-IDLE state. in_valid in those states is ignored, including in DONE when out_ready is high in the same cycle.
- Zero digits are looked up normally (ROM returns 0). There is no skipping, so latency is fixed.
- Outside ISSUE: lut_sel=0 and lut_digit=0.

## Timing
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, out_sum=0, busy=0, lut_sel=0, lut_digit=0. acc, idx, xpb_q, xpb_v and hi_q are all cleared.
- **Accept edge e0:** ISSUE for digit 0 follows e0.
- **Lookups:** lut_sel steps 0..NUM_DIGITS-1 in consecutive cycles. Edge e_k captures digit k-1.
- **Transitions:** DRAIN follows e_NUM_DIGITS. The final add occurs at e_(NUM_DIGITS+1), and DONE follows it.
- **Latency:** out_valid rises NUM_DIGITS+1 cycles after the accept edge (9 at defaults). Minimum issue interval is NUM_DIGITS+3 cycles with out_ready held high.
- **Backpressure:** DONE holds indefinitely; out_sum stays unchanged.
- **Reset mid-operation:** all state is discarded immediately and asynchronously; no partial sum is emitted.

## Structure
- **Package xpb_pkg:** WORD_BITS, DIGIT_BITS, NUM_DIGITS, ACC_BITS and the state enum, shared with the fold stage and ROM bank.
- **Sub-module xpb_wide_add:** combinational ACC_BITS-wide unsigned adder. Kept separate so it can later be swapped for a carry-save or DSP-chained implementation without touching the FSM.
- **Not in this block:** ROM bank instantiation; the parent owns the lut_sel mux.

## Test plan
Bench ROM model: value = (sel+1)*digit, unless stated otherwise.
- in_hi=0 -> after 9 cycles out_valid=1, out_sum=0; the 8 lookups carry lut_sel 0..7 and lut_digit 0.
- Only digit 3 set to 5 -> out_sum=20; lut_digit=5 seen only while lut_sel=3.
- All digits 31, with the model returning 2^1024-1 -> out_sum=8*(2^1024-1), using bit 1026 and showing no truncation.
- out_ready held low 5 cycles in DONE, with in_valid pulsed during them -> out_sum stable, in_ready=0, second word accepted only after the handshake and return to IDLE.
- rst_n asserted during ISSUE digit 4 -> next cycle all outputs at reset values. A new word then completes correctly with a fresh sum, with no residue from the aborted one.
- Back-to-back words with out_ready always 1 -> accepts spaced exactly 11 cycles apart; each sum matches the model.
